// File: rtl/des_pkg.sv
// DES key-schedule constants, bit-permutation helpers and scheduler state type
// shared by the sequential key scheduler and its CD step logic.
package des_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} key_sched_state_e;

   // Entry j names the 1-based key bit that lands in output bit j+1.
   localparam logic [5:0] PC1 [56] = '{
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
      6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
      6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
      6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4};

   localparam logic [5:0] PC2 [48] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

   localparam logic [1:0] SHIFTS [1:16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   // Stage order as "stage runs in decrypt direction" masks, indexed by stage.
   localparam logic [3:0] ENC_STAGE_DEC = 4'b0010;
   localparam logic [3:0] DEC_STAGE_DEC = 4'b0101;

   // C||D is kept MSB-first: PC1 output bit j (1-based) sits at [56-j].
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = 56'd0;
      for (int j = 0; j < 56; j++) begin
         r[55-j] = k[PC1[j] - 6'd1];
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = 48'd0;
      for (int j = 0; j < 48; j++) begin
         r[47-j] = cd[6'd56 - PC2[j]];
      end
      return r;
   endfunction

   function automatic logic [1:0] shift_amt(input logic [4:0] r);
      if ((r >= 5'd1) && (r <= 5'd16)) begin
         return SHIFTS[r];
      end else begin
         return 2'd0;
      end
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
      logic [27:0] r;
      case (n)
         2'd1:    r = {x[26:0], x[27]};
         2'd2:    r = {x[25:0], x[27:26]};
         default: r = x;
      endcase
      return r;
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
      logic [27:0] r;
      case (n)
         2'd1:    r = {x[0], x[27:1]};
         2'd2:    r = {x[1:0], x[27:2]};
         default: r = x;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/des_cd_step.sv
// One key-schedule step on C||D: forward from round r to r+1, or backward
// from round r to r-1. Used both for round advance and encrypt stage loads.
module des_cd_step
   import des_pkg::*;
(
   input  logic [55:0] cd_i,
   input  logic [4:0]  r_i,
   input  logic        dec_i,
   output logic [55:0] cd_o
);

   logic [1:0] amt_s;

   // Forward uses the shift of round r+1; backward undoes the shift of round r.
   always_comb begin
      if (dec_i) begin
         amt_s = shift_amt(r_i);
         cd_o  = {rotr28(cd_i[55:28], amt_s), rotr28(cd_i[27:0], amt_s)};
      end else begin
         amt_s = shift_amt(r_i + 5'd1);
         cd_o  = {rotl28(cd_i[55:28], amt_s), rotl28(cd_i[27:0], amt_s)};
      end
   end

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES/3DES key scheduler: accepts a 1- or 3-key bundle and streams
// one 48-bit round key per handshake in encrypt or decrypt order.
module des_key_sched_seq
   import des_pkg::*;
#(
   parameter int NUM_KEYS = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   key_valid,
   output logic                   key_ready,
   input  logic [64*NUM_KEYS-1:0] key_in,
   input  logic                   decrypt,
   input  logic                   abort,
   output logic                   rk_valid,
   input  logic                   rk_ready,
   output logic [47:0]            rk_data,
   output logic [3:0]             rk_round,
   output logic [1:0]             rk_stage,
   output logic                   rk_dec,
   output logic                   rk_last
);

   if ((NUM_KEYS != 1) && (NUM_KEYS != 3)) begin : g_bad_num_keys
      $error("des_key_sched_seq: NUM_KEYS must be 1 or 3");
   end

   key_sched_state_e       state_q, state_d;
   logic [64*NUM_KEYS-1:0] key_q, key_d;
   logic [55:0]            cd_q, cd_d;
   logic [3:0]             round_q, round_d;
   logic [1:0]             stage_q, stage_d;
   logic                   dec_q, dec_d;

   logic                   run_s, hs_s, last_s, stage_dec_s;
   logic [4:0]             r_cur_s, step_r_s;
   logic [64*NUM_KEYS-1:0] key_src_s;
   logic [63:0]            keys_s [4];
   logic                   load_sel_s, load_order_dec_s, load_dir_dec_s, step_dec_s;
   logic [1:0]             load_stage_s, load_idx_s;
   logic [55:0]            load_pc1_s, step_in_s, step_out_s, load_cd_s;

   assign run_s       = (state_q == RUN);
   assign stage_dec_s = dec_q ? DEC_STAGE_DEC[stage_q] : ENC_STAGE_DEC[stage_q];
   assign r_cur_s     = stage_dec_s ? (5'd16 - {1'b0, round_q}) : ({1'b0, round_q} + 5'd1);
   assign last_s      = run_s && (stage_q == 2'(NUM_KEYS - 1)) && (round_q == 4'd15);
   assign hs_s        = run_s && rk_ready;

   // In IDLE the first stage loads straight from the input bus; in RUN the next stage loads from the bundle register.
   assign key_src_s        = run_s ? key_q : key_in;
   assign load_order_dec_s = run_s ? dec_q : decrypt;
   assign load_stage_s     = run_s ? (stage_q + 2'd1) : 2'd0;
   assign load_dir_dec_s   = load_order_dec_s ? DEC_STAGE_DEC[load_stage_s] : ENC_STAGE_DEC[load_stage_s];
   assign load_idx_s       = load_order_dec_s ? (2'(NUM_KEYS - 1) - load_stage_s) : load_stage_s;

   for (genvar g = 0; g < 4; g++) begin : g_keys
      if (g < NUM_KEYS) begin : g_used
         assign keys_s[g] = key_src_s[64*g +: 64];
      end else begin : g_pad
         assign keys_s[g] = 64'd0;
      end
   end

   assign load_pc1_s = pc1(keys_s[load_idx_s]);
   assign load_sel_s = !run_s || (round_q == 4'd15);
   assign step_in_s  = load_sel_s ? load_pc1_s : cd_q;
   assign step_r_s   = load_sel_s ? 5'd0 : r_cur_s;
   assign step_dec_s = load_sel_s ? 1'b0 : stage_dec_s;

   des_cd_step u_cd_step (
      .cd_i  (step_in_s),
      .r_i   (step_r_s),
      .dec_i (step_dec_s),
      .cd_o  (step_out_s)
   );

   // A decrypt stage starts at C16D16, which equals C0D0, so PC1 is loaded unshifted.
   assign load_cd_s = load_dir_dec_s ? load_pc1_s : step_out_s;

   // Next-state logic: abort dominates, then key load, round advance and stage change.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cd_d    = cd_q;
      round_d = round_q;
      stage_d = stage_q;
      dec_d   = dec_q;
      if (abort) begin
         state_d = IDLE;
         key_d   = {(64*NUM_KEYS){1'b0}};
         cd_d    = 56'd0;
         round_d = 4'd0;
         stage_d = 2'd0;
         dec_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (key_valid) begin
                  state_d = RUN;
                  key_d   = key_in;
                  dec_d   = decrypt;
                  cd_d    = load_cd_s;
                  round_d = 4'd0;
                  stage_d = 2'd0;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (hs_s && last_s) begin
                  state_d = IDLE;
                  key_d   = {(64*NUM_KEYS){1'b0}};
                  cd_d    = 56'd0;
                  round_d = 4'd0;
                  stage_d = 2'd0;
                  dec_d   = 1'b0;
               end else if (hs_s && (round_q == 4'd15)) begin
                  stage_d = stage_q + 2'd1;
                  round_d = 4'd0;
                  cd_d    = load_cd_s;
               end else if (hs_s) begin
                  round_d = round_q + 4'd1;
                  cd_d    = step_out_s;
               end else begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = IDLE;
               key_d   = {(64*NUM_KEYS){1'b0}};
               cd_d    = 56'd0;
               round_d = 4'd0;
               stage_d = 2'd0;
               dec_d   = 1'b0;
            end
         endcase
      end
   end

   // State and schedule registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= {(64*NUM_KEYS){1'b0}};
         cd_q    <= 56'd0;
         round_q <= 4'd0;
         stage_q <= 2'd0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cd_q    <= cd_d;
         round_q <= round_d;
         stage_q <= stage_d;
         dec_q   <= dec_d;
      end
   end

   assign key_ready = !run_s;
   assign rk_valid  = run_s;
   assign rk_data   = pc2(cd_q);
   assign rk_round  = round_q;
   assign rk_stage  = stage_q;
   assign rk_dec    = run_s && stage_dec_s;
   assign rk_last   = last_s;

endmodule

// File: doc/des_key_sched_seq.md
# des_key_sched_seq

Sequential, parametrised DES/3DES key scheduler that replaces the fully unrolled 16-stage combinational schedule. It accepts a 1- or 3-key bundle over a valid/ready handshake and streams round keys one per accepted beat, in encrypt or decrypt order, to an iterative round datapath. It sits between the key-load interface and the cipher round engine.

## Interface
- NUM_KEYS, default 1: keys per bundle; 1 = single DES, 3 = 3DES EDE. Other values are illegal and fail elaboration.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  key bundle offered.
- key_ready  out  1  high in IDLE only.
- key_in  in  64*NUM_KEYS  K1 = [63:0], K2 = [127:64], K3 = [191:128]. DES key bit n (1-based) maps to [n-1]; parity bits are ignored.
- decrypt  in  1  direction, sampled with key_in.
- abort  in  1  synchronous flush.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts.
- rk_data  out  48  round key. PC-2 output bit j (1-based) maps to [48-j].
- rk_round  out  4  output-order index 0..15 within the stage.
- rk_stage  out  2  stage 0..NUM_KEYS-1.
- rk_dec  out  1  this stage is used in decrypt direction.
- rk_last  out  1  final key of the bundle.

## Operation
- **FSM states:** IDLE and RUN.
- **IDLE:**
  - key_ready=1.
  - On key_valid, capture key_in and decrypt, load cd from the first stage's key, and go to RUN.
- **Stage order:**
  - Encrypt: (K1, enc), (K2, dec), (K3, enc).
  - Decrypt: (K3, dec), (K2, enc), (K1, dec).
  - For NUM_KEYS=1 there is a single stage: K1 with rk_dec=decrypt.
- **cd register** holds C_r‖D_r (56 bits) for the current DES round r.
- **Shift table:** SHIFTS[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- **Stage load:**
  - Encrypt stage: cd = rotl(PC1(K), 1), i.e. r=1.
  - Decrypt stage: cd = PC1(K), i.e. C16D16 = C0D0, r=16.
- **Advance** on each rk handshake (rk_valid & rk_ready):
  - Encrypt: r→r+1, each 28-bit half rotated left by SHIFTS[r+1].
  - Decrypt: r→r-1, each half rotated right by SHIFTS[r].
- **Stage boundary:** after rk_round=15 the next stage loads directly, with no bubble.
- **Output decode:**
  - rk_data = PC2(cd), combinational from the register.
  - rk_round counts 0..15 in output order.
  - rk_last = (rk_stage==NUM_KEYS-1) & (rk_round==15).
- **Completion:** the handshake with rk_last returns the FSM to IDLE. The key bundle register and cd are zeroed on that edge.
- **abort:**
  - Highest priority in any state.
  - Next state is IDLE; key and cd are zeroed; rk_valid is low next cycle.
  - abort during key_valid in IDLE drops the key.
- **Key acceptance:** no key is accepted while in RUN, and none on the cycle the FSM returns to IDLE (key_ready is state-decoded).

## Timing
- **Reset values:**
  - key_ready=1 (state IDLE).
  - rk_valid=0, rk_data=0, rk_round=0, rk_stage=0, rk_dec=0, rk_last=0.
  - cd and key register = 0.
- **Latency:** key accepted at edge N gives rk_valid=1 with the first key after edge N.
- **Throughput:** one key per cycle while rk_ready=1. A bundle drains in 16*NUM_KEYS cycles minimum.
- **Backpressure:** while rk_valid & !rk_ready, all rk_* outputs hold stable.
- **Turnaround:** the rk_last handshake at edge M gives key_ready=1 after M. The next key is accepted no earlier than edge M+1.
- **Async reset mid-RUN:** outputs go to their reset values immediately. No partial key survives.

## Structure
- **Package des_pkg:**
  - Constants PC1 (56 entries), PC2 (48 entries) and SHIFTS.
  - Functions pc1(), pc2(), rotl28(), rotr28().
  - State typedef key_sched_state_e {IDLE, RUN}.
  - Stage-order constant arrays for encrypt/decrypt.
- **Sub-module des_cd_step:** combinational. Inputs cd, r, dir. Output next cd. It is shared by the advance and stage-load paths.

## Test plan
- **DES encrypt:**
  - Stimulus: NUM_KEYS=1, decrypt=0, key_in=64'h8FFB3DD99EEA2CC8 (FIPS key 133457799BBCDFF1), rk_ready=1.
  - Response: keys on 16 consecutive cycles. Round 0 = 48'h1B02EFFC7072, round 15 = 48'hCB3D8B0E17F5, rk_last on round 15, key_ready the cycle after.
- **DES decrypt:** same key with decrypt=1. Round 0 = CB3D8B0E17F5, round 15 = 1B02EFFC7072, full sequence the exact reverse of the encrypt case.
- **3DES:**
  - Stimulus: NUM_KEYS=3, K1=K2=K3=that key, encrypt.
  - Response: 48 keys. Stage 1 is in reverse order with rk_dec=1. rk_stage steps 0→1→2 with no gap. rk_last is asserted only on beat 48.
- **Backpressure:** toggle rk_ready randomly. Outputs stay stable while stalled, the sequence is identical to the rk_ready=1 run, and no key is skipped or duplicated.
- **abort:** assert abort at round 7. rk_valid=0 next cycle, key_ready=1. A new key then yields its correct round 0.
- **Reset:** deassert rst_n mid-RUN. All outputs are at reset values asynchronously; after release the block is IDLE with key_ready=1.
